// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Bursts of up to BURST_LEN beats; every beat is gated on the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       full,
    output logic                       wr_en,
    output logic [WIDTH-1:0]           wdata,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_n;
    logic [ID_W-1:0]   owner, owner_n;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;

    logic              accept;
    logic              release_grant;
    logic              any_req;
    logic [ID_W-1:0]   sel;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + ID_W'(1);
    endfunction

    // Scans from the far end back toward p, so the last hit is the first in rotating order.
    function automatic logic [ID_W-1:0] pick(input logic [ID_W-1:0] p,
                                             input logic [NUM_REQ-1:0] r);
        logic [ID_W-1:0] result;
        int              idx;
        result = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NUM_REQ;
            if (r[idx]) result = ID_W'(idx);
        end
        return result;
    endfunction

    // Write-side datapath: zero latency from req/full to the FIFO port.
    always_comb begin
        accept   = (state == GRANT) && req[owner] && !full;
        wr_en    = accept;
        wdata    = accept ? req_data[int'(owner)*WIDTH +: WIDTH] : '0;
        ack      = accept ? (NUM_REQ'(1) << owner) : '0;
        busy     = (state == GRANT);
        grant_id = owner;
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n       = state;
        owner_n       = owner;
        rr_ptr_n      = rr_ptr;
        beat_cnt_n    = beat_cnt;
        any_req       = |req;
        sel           = pick(rr_ptr, req);
        release_grant = !req[owner] || (accept && (beat_cnt == LAST_BEAT));

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n    = GRANT;
                    owner_n    = sel;
                    beat_cnt_n = '0;
                    rr_ptr_n   = wrap_inc(sel);
                end
            end
            GRANT: begin
                if (release_grant) begin
                    if (any_req) begin
                        owner_n    = sel;
                        beat_cnt_n = '0;
                        rr_ptr_n   = wrap_inc(sel);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected beats and
// sampled checks; a negedge monitor pops and compares them.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int ID_W      = 2;

    logic                     clk = 1'b0;
    logic                     res;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic                     full;
    logic                     wr_en;
    logic [WIDTH-1:0]         wdata;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .full    (full),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .grant_id(grant_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    beat_t            exp_q[$];
    chk_t             chk_q[$];
    logic [WIDTH-1:0] src_q[NUM_REQ][$];
    logic [NUM_REQ-1:0] ack_s;
    int               n_assert = 0;
    int               n_fail   = 0;
    int               wr_cnt   = 0;
    int               w0;
    chk_t             mon_c;
    beat_t            mon_e;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic exp_beat(input int id, input logic [WIDTH-1:0] data);
        beat_t b;
        b.id   = ID_W'(id);
        b.data = data;
        exp_q.push_back(b);
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            mon_c = chk_q.pop_front();
            n_assert++;
            if (mon_c.act !== mon_c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, want 0x%0h", mon_c.name, mon_c.act, mon_c.exp);
            end
        end
        if (!res && wr_en) begin
            wr_cnt++;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got id %0d data 0x%0h, want no write",
                         grant_id, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (wdata !== mon_e.data || grant_id !== mon_e.id ||
                    ack !== (NUM_REQ'(1) << mon_e.id)) begin
                    n_fail++;
                    $display("FAIL write: got id %0d data 0x%0h ack %b, want id %0d data 0x%0h",
                             grant_id, wdata, ack, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) begin
                req[i]                   = 1'b1;
                req_data[i*WIDTH +: WIDTH] = src_q[i][0];
            end else begin
                req[i]                   = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    // One clock: sample ack away from the edge, retire acked beats, present next ones.
    task automatic cycle();
        @(negedge clk);
        ack_s = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (ack_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        drive();
        #1;
    endtask

    function automatic logic pending();
        logic p;
        p = busy;
        for (int i = 0; i < NUM_REQ; i++) p |= (src_q[i].size() != 0);
        return p;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (pending() && n < 300) begin
            cycle();
            n++;
        end
        expect_eq("drain_done", {31'd0, pending()}, 0);
        expect_eq("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        drive();
        full = 1'b0;
        res  = 1'b1;
        @(negedge clk);
        #1;
        res = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        res      = 1'b1;
        full     = 1'b0;
        req      = '0;
        req_data = '0;
        #2;
        expect_eq("rst_wr_en", {31'd0, wr_en}, 0);
        expect_eq("rst_ack", {28'd0, ack}, 0);
        expect_eq("rst_busy", {31'd0, busy}, 0);
        expect_eq("rst_grant_id", {30'd0, grant_id}, 0);
        expect_eq("rst_wdata", {24'd0, wdata}, 0);
        @(negedge clk);
        #1;
        res = 1'b0;
        @(posedge clk);
        #2;

        // Empty: no requests, nothing written
        w0 = wr_cnt;
        for (int k = 0; k < 20; k++) begin
            cycle();
            expect_eq("empty_wr_en", {31'd0, wr_en}, 0);
            expect_eq("empty_busy", {31'd0, busy}, 0);
        end
        expect_eq("empty_fifo_writes", wr_cnt - w0, 0);

        // Single requester, 6 beats: burst boundary re-grants owner 0 without a bubble
        do_reset();
        for (int j = 0; j < 6; j++) begin
            src_q[0].push_back(WIDTH'(8'h10 + j));
            exp_beat(0, WIDTH'(8'h10 + j));
        end
        drive();
        #1;
        expect_eq("single_idle_wr_en", {31'd0, wr_en}, 0);
        expect_eq("single_idle_busy", {31'd0, busy}, 0);
        cycle();
        for (int k = 0; k < 6; k++) begin
            expect_eq("single_wr_en", {31'd0, wr_en}, 1);
            expect_eq("single_grant", {30'd0, grant_id}, 0);
            cycle();
        end
        expect_eq("single_tail_busy", {31'd0, busy}, 1);
        expect_eq("single_tail_wr_en", {31'd0, wr_en}, 0);
        cycle();
        expect_eq("single_busy_drop", {31'd0, busy}, 0);
        expect_eq("single_last_owner", {30'd0, grant_id}, 0);
        drain();

        // Fairness: all four requesting, two rounds of 4-beat grants
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 8; j++) src_q[i].push_back(WIDTH'(i * 16 + j));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                for (int j = 0; j < 4; j++) exp_beat(i, WIDTH'(i * 16 + r * 4 + j));
        drive();
        #1;
        cycle();
        for (int k = 0; k < 32; k++) begin
            expect_eq("fair_wr_en", {31'd0, wr_en}, 1);
            expect_eq("fair_grant", {30'd0, grant_id}, (k / 4) % 4);
            expect_eq("fair_onehot", {31'd0, $onehot(ack)}, 1);
            cycle();
        end
        drain();

        // Full stall: owner 2 at beat_cnt 1 held for 5 cycles
        do_reset();
        w0 = wr_cnt;
        for (int j = 0; j < 4; j++) begin
            src_q[2].push_back(WIDTH'(8'hA0 + j));
            exp_beat(2, WIDTH'(8'hA0 + j));
        end
        drive();
        #1;
        cycle();
        cycle();
        full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            expect_eq("stall_wr_en", {31'd0, wr_en}, 0);
            expect_eq("stall_ack", {28'd0, ack}, 0);
            expect_eq("stall_grant", {30'd0, grant_id}, 2);
            expect_eq("stall_busy", {31'd0, busy}, 1);
            cycle();
        end
        full = 1'b0;
        drain();
        expect_eq("stall_total_writes", wr_cnt - w0, 4);

        // Drop: owner 1 leaves after 2 beats, owner 3 takes over, then pick restarts at 0
        do_reset();
        for (int j = 0; j < 4; j++) src_q[1].push_back(WIDTH'(8'h50 + j));
        src_q[3].push_back(8'h70);
        src_q[3].push_back(8'h71);
        exp_beat(1, 8'h50);
        exp_beat(1, 8'h51);
        exp_beat(3, 8'h70);
        exp_beat(3, 8'h71);
        exp_beat(0, 8'h0A);
        exp_beat(2, 8'h2A);
        drive();
        #1;
        cycle();
        cycle();
        cycle();
        src_q[1].delete();
        drive();
        #1;
        expect_eq("drop_wr_en", {31'd0, wr_en}, 0);
        expect_eq("drop_grant", {30'd0, grant_id}, 1);
        cycle();
        expect_eq("drop_handoff_grant", {30'd0, grant_id}, 3);
        expect_eq("drop_handoff_wr_en", {31'd0, wr_en}, 1);
        src_q[0].push_back(8'h0A);
        src_q[2].push_back(8'h2A);
        drive();
        #1;
        drain();

        // Reset mid-burst during owner 2's third beat
        do_reset();
        for (int j = 0; j < 4; j++) src_q[2].push_back(WIDTH'(8'hC0 + j));
        exp_beat(2, 8'hC0);
        exp_beat(2, 8'hC1);
        drive();
        #1;
        cycle();
        cycle();
        cycle();
        expect_eq("rstmid_pre_wr_en", {31'd0, wr_en}, 1);
        #1;
        res = 1'b1;
        #1;
        expect_eq("rstmid_wr_en", {31'd0, wr_en}, 0);
        expect_eq("rstmid_ack", {28'd0, ack}, 0);
        expect_eq("rstmid_busy", {31'd0, busy}, 0);
        expect_eq("rstmid_grant", {30'd0, grant_id}, 0);
        expect_eq("rstmid_wdata", {24'd0, wdata}, 0);
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        src_q[1].push_back(8'hB1);
        src_q[2].push_back(8'hB2);
        exp_beat(1, 8'hB1);
        exp_beat(2, 8'hB2);
        drive();
        @(negedge clk);
        #1;
        res = 1'b0;
        @(posedge clk);
        #2;
        expect_eq("rstmid_first_grant", {30'd0, grant_id}, 1);
        expect_eq("rstmid_first_busy", {31'd0, busy}, 1);
        drain();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a FIFO among NUM_REQ requesters. It grants one requester at a time for a burst of up to BURST_LEN beats. It drives the FIFO's wr_en/wdata directly and gates every beat on the FIFO's full flag, so the FIFO can never overflow. It sits on the write side of the FIFO in the same clock domain as wr_clk; the port named clk here is connected to it.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width; must equal the FIFO WIDTH
BURST_LEN, 4, maximum beats per grant (>=1)
ID_W, $clog2(NUM_REQ), width of grant_id (derived)

Ports:
clk  input  1  write-side clock; all state updates on posedge
res  input  1  reset; asynchronous, active-high
req  input  NUM_REQ  req[i]=1: requester i has a beat ready on its data slice
req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
ack  output  NUM_REQ  one-hot; ack[i]=1: requester i's beat is written this cycle
full  input  1  FIFO full flag
wr_en  output  1  FIFO write enable
wdata  output  WIDTH  FIFO write data
grant_id  output  ID_W  index of the current or last owner
busy  output  1  1 while in GRANT

Behaviour:
- Registered state: state (IDLE/GRANT), owner[ID_W], rr_ptr[ID_W] (highest-priority index), beat_cnt[$clog2(BURST_LEN+1)].
- Reset (async, res=1): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. Outputs during and immediately after reset: wr_en=0, ack=0, busy=0, grant_id=0, wdata=0.
- Combinational datapath, zero latency:
  - accept = (state==GRANT) & req[owner] & ~full.
  - wr_en = accept.
  - wdata = accept ? req_data slice[owner] : 0.
  - ack = accept ? (1<<owner) : 0.
- Selection function pick(p): the first index k in the order p, p+1, ..., p+NUM_REQ-1 (mod NUM_REQ) with req[k]=1.
- IDLE: if |req, then state<=GRANT, owner<=pick(rr_ptr), beat_cnt<=0, rr_ptr<=pick(rr_ptr)+1 mod NUM_REQ. No beat is written in IDLE, so the first grant costs one cycle.
- GRANT, release condition = ~req[owner] | (accept & beat_cnt==BURST_LEN-1):
  - No release: beat_cnt increments on accept; otherwise holds.
  - Release with |req (current-cycle values, the owner included only if its req is still high): owner<=pick(rr_ptr), beat_cnt<=0, rr_ptr advances past the new owner, and the state stays GRANT. The handoff has no bubble.
  - Release with no req pending: state<=IDLE; owner holds, so grant_id keeps showing the last owner.
- Full stall: while full=1, no accept. Grant, beat_cnt and rr_ptr all hold. A stalled owner keeps the grant indefinitely while its req stays high.
- Requester drop: the owner deasserting req mid-burst releases the grant that cycle, even if full=1. A partial burst counts as a full turn.
- Non-owner req lines are ignored until the next selection. Requesters must hold req and data stable until ack.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. The owner just released has the lowest priority at the next pick.
- Reset mid-burst: wr_en and ack drop immediately (asynchronously), and all state returns to reset values.
- busy = (state==GRANT). grant_id = owner.

Test Plan:
- Single requester: req[0] high for 6 beats (data 0x10..0x15), full=0 -> IDLE 1 cycle, then 6 consecutive writes 0x10..0x15. Handoff at beat 4 re-grants owner 0 with no bubble. busy falls 1 cycle after the last ack.
- Fairness: req=4'b1111 held continuously -> grant_id sequence 0,1,2,3,0. Each grant lasts exactly 4 write cycles with no idle cycles between grants, and ack is one-hot every cycle.
- Full stall: owner 2 mid-burst at beat_cnt=1, full=1 for 5 cycles -> wr_en=0 and ack=0 for those 5 cycles, grant_id stays 2. On full=0 the remaining 3 beats complete in order, and total FIFO writes equal 4 with no overflow.
- Drop: owner 1 deasserts req after 2 beats while req[3]=1 -> the next cycle grant_id=3 with no bubble. The subsequent pick starts at index 0.
- Reset mid-burst: res=1 asynchronously during owner 2's beat 2 -> wr_en=0, ack=0, busy=0, grant_id=0 immediately. After release with req=4'b0110, the first grant goes to 1.
- Empty: req=0 for 20 cycles after reset -> wr_en stays 0 and busy stays 0, and connected FIFO empty remains 1.
